// File: rtl/strobe_bank_pkg.sv
// Shared constants and helpers for the strobe bank: mode encodings, jitter
// rotation step, PRNG reset state, packed-field and rotate helpers.
package strobe_bank_pkg;

  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_BURST      = 1'b1;

  localparam int unsigned JITTER_ROT_STEP = 8;
  localparam int unsigned FIELD_VEC_W     = 256;

  localparam logic [127:0] PRNG_RESET = {32'h5851F42D, 32'hB7E15162,
                                         32'h243F6A88, 32'h9E3779B9};

  // Field k of a packed vector of w-bit fields, zero-extended to FIELD_VEC_W.
  function automatic logic [FIELD_VEC_W-1:0] field_get(
      input logic [FIELD_VEC_W-1:0] vec,
      input int unsigned            k,
      input int unsigned            w);
    logic [FIELD_VEC_W-1:0] mask;
    mask = {FIELD_VEC_W{1'b1}} >> (FIELD_VEC_W - w);
    return (vec >> (k * w)) & mask;
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] v,
                                         input int unsigned n);
    int unsigned s;
    s = n % 32;
    return (v >> s) | (v << (32 - s));
  endfunction

endpackage

// File: rtl/prngXoshiro128p.sv
// Xoshiro128+ generator; a seed byte shifts into the low end of the state
// instead of advancing it.
module prngXoshiro128p
  import strobe_bank_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [7:0]  seed_byte_i,
  input  logic        seed_valid_i,
  output logic [31:0] result_o
);

  logic [127:0] st_q, st_d;
  logic [31:0]  s0, s1, s2, s3, t, n0, n1, n2, n3;

  always_comb begin
    s0 = st_q[31:0];
    s1 = st_q[63:32];
    s2 = st_q[95:64];
    s3 = st_q[127:96];
    t  = s1 << 9;
    n2 = s2 ^ s0;
    n3 = s3 ^ s1;
    n1 = s1 ^ n2;
    n0 = s0 ^ n3;
    n2 = n2 ^ t;
    n3 = {n3[20:0], n3[31:21]};
    if (seed_valid_i) st_d = {st_q[119:0], seed_byte_i};
    else              st_d = {n3, n2, n1, n0};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     st_q <= PRNG_RESET;
    else if (en_i) st_q <= st_d;
  end

  assign result_o = s0 + s3;

endmodule

// File: rtl/strobe_bank_chan.sv
// One strobe channel: reload counter, burst remaining count, registered strobe.
module strobe_bank_chan
  import strobe_bank_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned BURST_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cg_i,
  input  logic                enable_i,
  input  logic                mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [PERIOD_W-1:0] phase_i,
  input  logic [BURST_W-1:0]  burst_i,
  input  logic                sync_i,
  input  logic                trigger_i,
  input  logic                jit_i,
  output logic                strobe_o,
  output logic                busy_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [BURST_W-1:0]  brem_q, brem_d;
  logic                strobe_q, strobe_d, busy_q, busy_d;
  logic                active, cnt_zero;

  always_comb begin
    active   = enable_i && (mode_i == MODE_CONTINUOUS || brem_q != '0);
    cnt_zero = (cnt_q == '0);
    strobe_d = active && cnt_zero && !jit_i && !strobe_q && !sync_i;
    cnt_d    = cnt_q;
    brem_d   = brem_q;
    if (!enable_i || sync_i) begin
      cnt_d = phase_i;
    end else if (mode_i == MODE_BURST && brem_q == '0) begin
      cnt_d = phase_i;
      if (trigger_i && burst_i != '0) brem_d = burst_i;
    end else if (cnt_zero) begin
      // jitter parks the counter at zero, postponing the strobe
      cnt_d = jit_i ? '0 : period_i;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    if (!enable_i) brem_d = '0;
    else if (strobe_d && mode_i == MODE_BURST && brem_q != '0) brem_d = brem_q - 1'b1;
    busy_d = (brem_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      brem_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else if (cg_i) begin
      cnt_q    <= cnt_d;
      brem_q   <= brem_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  assign strobe_o = strobe_q;
  assign busy_o   = busy_q;

endmodule

// File: rtl/strobe_bank.sv
// Bank of N_CHAN strobe generators sharing one Xoshiro128+ jitter source.
module strobe_bank
  import strobe_bank_pkg::*;
#(
  parameter int unsigned N_CHAN        = 4,
  parameter int unsigned CTRL_PERIOD_W = 16,
  parameter int unsigned CTRL_JITTER_W = 8,
  parameter int unsigned CTRL_BURST_W  = 8,
  parameter int unsigned ENABLE_JITTER = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_cg,
  input  logic [N_CHAN-1:0]                 i_ctrlEnable,
  input  logic [N_CHAN-1:0]                 i_ctrlMode,
  input  logic [N_CHAN*CTRL_PERIOD_W-1:0]   i_ctrlPeriod,
  input  logic [N_CHAN*CTRL_PERIOD_W-1:0]   i_ctrlPhase,
  input  logic [N_CHAN*CTRL_JITTER_W-1:0]   i_ctrlJitter,
  input  logic [N_CHAN*CTRL_BURST_W-1:0]    i_ctrlBurst,
  input  logic                              i_sync,
  input  logic [N_CHAN-1:0]                 i_trigger,
  input  logic [7:0]                        i_jitterSeedByte,
  input  logic                              i_jitterSeedValid,
  output logic [31:0]                       o_jitterPrng,
  output logic [N_CHAN-1:0]                 o_strobe,
  output logic [N_CHAN-1:0]                 o_busy
);

  logic [31:0] prng_w;

  if (ENABLE_JITTER != 0) begin : g_prng
    prngXoshiro128p u_prng (
      .clk_i        (i_clk),
      .rst_i        (i_rst),
      .en_i         (i_cg),
      .seed_byte_i  (i_jitterSeedByte),
      .seed_valid_i (i_jitterSeedValid),
      .result_o     (prng_w)
    );
  end else begin : g_no_prng
    assign prng_w = '0;
  end

  assign o_jitterPrng = prng_w;

  for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
    logic [CTRL_JITTER_W-1:0] rot_top, thr;
    logic                     jit;

    // each channel compares a differently rotated slice of the shared PRNG word
    assign rot_top = CTRL_JITTER_W'(rotr32(prng_w, JITTER_ROT_STEP * k) >> (32 - CTRL_JITTER_W));
    assign thr     = CTRL_JITTER_W'(field_get(FIELD_VEC_W'(i_ctrlJitter), k, CTRL_JITTER_W));
    assign jit     = (ENABLE_JITTER != 0) && (rot_top < thr);

    strobe_bank_chan #(
      .PERIOD_W (CTRL_PERIOD_W),
      .BURST_W  (CTRL_BURST_W)
    ) u_chan (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .cg_i      (i_cg),
      .enable_i  (i_ctrlEnable[k]),
      .mode_i    (i_ctrlMode[k]),
      .period_i  (CTRL_PERIOD_W'(field_get(FIELD_VEC_W'(i_ctrlPeriod), k, CTRL_PERIOD_W))),
      .phase_i   (CTRL_PERIOD_W'(field_get(FIELD_VEC_W'(i_ctrlPhase), k, CTRL_PERIOD_W))),
      .burst_i   (CTRL_BURST_W'(field_get(FIELD_VEC_W'(i_ctrlBurst), k, CTRL_BURST_W))),
      .sync_i    (i_sync),
      .trigger_i (i_trigger[k]),
      .jit_i     (jit),
      .strobe_o  (o_strobe[k]),
      .busy_o    (o_busy[k])
    );
  end

endmodule

// File: tb/tb_strobe_bank.sv
// Directed and randomized bench for strobe_bank against a due-time reference
// model with its own Xoshiro128+ implementation.
module tb_strobe_bank;

  localparam int N  = 4;
  localparam int PW = 16;
  localparam int JW = 8;
  localparam int BW = 8;
  localparam logic [127:0] RST_STATE = {32'h5851F42D, 32'hB7E15162,
                                        32'h243F6A88, 32'h9E3779B9};

  logic              clk = 1'b0;
  logic              rst, cg, sync, seedv;
  logic [7:0]        seedb;
  logic [N-1:0]      en_v, mode_v, trig_v;
  logic [N*PW-1:0]   per_v, ph_v;
  logic [N*JW-1:0]   jit_v;
  logic [N*BW-1:0]   bu_v;
  logic [31:0]       prng_o, nj_prng_o;
  logic [N-1:0]      strobe_o, busy_o, nj_strobe_o, nj_busy_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit nojit_phase = 1'b1;

  int           m_due [N];
  int           m_brem[N];
  bit [N-1:0]   m_str, m_busy;
  logic [127:0] m_st;

  always #5 clk = ~clk;

  strobe_bank #(
    .N_CHAN(N), .CTRL_PERIOD_W(PW), .CTRL_JITTER_W(JW), .CTRL_BURST_W(BW), .ENABLE_JITTER(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_ctrlEnable(en_v), .i_ctrlMode(mode_v),
    .i_ctrlPeriod(per_v), .i_ctrlPhase(ph_v), .i_ctrlJitter(jit_v), .i_ctrlBurst(bu_v),
    .i_sync(sync), .i_trigger(trig_v), .i_jitterSeedByte(seedb),
    .i_jitterSeedValid(seedv), .o_jitterPrng(prng_o), .o_strobe(strobe_o), .o_busy(busy_o)
  );

  strobe_bank #(
    .N_CHAN(N), .CTRL_PERIOD_W(PW), .CTRL_JITTER_W(JW), .CTRL_BURST_W(BW), .ENABLE_JITTER(0)
  ) dut_nj (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_ctrlEnable(en_v), .i_ctrlMode(mode_v),
    .i_ctrlPeriod(per_v), .i_ctrlPhase(ph_v), .i_ctrlJitter(jit_v), .i_ctrlBurst(bu_v),
    .i_sync(sync), .i_trigger(trig_v), .i_jitterSeedByte(seedb),
    .i_jitterSeedValid(seedv), .o_jitterPrng(nj_prng_o), .o_strobe(nj_strobe_o), .o_busy(nj_busy_o)
  );

  function automatic logic [31:0] x_result(input logic [127:0] st);
    return st[31:0] + st[127:96];
  endfunction

  function automatic logic [127:0] x_next(input logic [127:0] st);
    logic [31:0] s [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) s[i] = st[32*i +: 32];
    t = s[1] << 9;
    s[2] ^= s[0];
    s[3] ^= s[1];
    s[1] ^= s[2];
    s[0] ^= s[3];
    s[2] ^= t;
    s[3] = (s[3] << 11) | (s[3] >> 21);
    return {s[3], s[2], s[1], s[0]};
  endfunction

  function automatic logic [7:0] jit_slice(input logic [31:0] p, input int k);
    logic [63:0] d;
    logic [31:0] r;
    d = {p, p};
    r = 32'(d >> ((8 * k) % 32));
    return r[31:24];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the reference by one clock from the current inputs, then compare.
  task automatic tick();
    logic [31:0] p;
    bit jit, cnt0, active, sd, en, md;
    int per, ph, bu, nbrem;
    p = x_result(m_st);
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_due[k] = cyc + 1;
        m_brem[k] = 0;
      end
      m_str = '0;
      m_busy = '0;
      m_st = RST_STATE;
    end else if (!cg) begin
      for (int k = 0; k < N; k++) m_due[k] = m_due[k] + 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        en  = en_v[k];
        md  = mode_v[k];
        per = int'(per_v[k*PW +: PW]);
        ph  = int'(ph_v[k*PW +: PW]);
        bu  = int'(bu_v[k*BW +: BW]);
        jit = (jit_slice(p, k) < jit_v[k*JW +: JW]);
        cnt0 = (m_due[k] == cyc);
        active = en && (!md || m_brem[k] != 0);
        sd = active && cnt0 && !jit && !m_str[k] && !sync;
        nbrem = m_brem[k];
        if (!en || sync) m_due[k] = cyc + 1 + ph;
        else if (md && m_brem[k] == 0) begin
          m_due[k] = cyc + 1 + ph;
          if (trig_v[k] && bu != 0) nbrem = bu;
        end else if (cnt0) m_due[k] = jit ? cyc + 1 : cyc + 1 + per;
        if (!en) nbrem = 0;
        else if (sd && md && m_brem[k] != 0) nbrem = m_brem[k] - 1;
        m_str[k]  = sd;
        m_brem[k] = nbrem;
        m_busy[k] = (nbrem != 0);
      end
      m_st = seedv ? {m_st[119:0], seedb} : x_next(m_st);
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("strobe", 32'(strobe_o), 32'(m_str));
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("prng", prng_o, x_result(m_st));
    chk("nojitter_prng_zero", nj_prng_o, 32'd0);
    if (nojit_phase) begin
      chk("nojitter_strobe", 32'(nj_strobe_o), 32'(m_str));
      chk("nojitter_busy", 32'(nj_busy_o), 32'(m_busy));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int last [N];
    rst = 1'b1; cg = 1'b1; sync = 1'b0; seedv = 1'b0; seedb = '0;
    en_v = '0; mode_v = '0; trig_v = '0;
    per_v = '0; ph_v = '0; jit_v = '0; bu_v = '0;
    run(2);
    rst = 1'b0;

    // continuous, period 3, phase 0
    en_v[0] = 1'b1;
    per_v[0 +: PW] = 16'd3;
    run(20);

    // period 0 alternates; gate the clock for 3 cycles mid-stream
    per_v[0 +: PW] = 16'd0;
    run(6);
    cg = 1'b0;
    run(3);
    cg = 1'b1;
    run(4);

    // four channels realigned by sync with staggered phases
    en_v = '1;
    for (int k = 0; k < N; k++) begin
      per_v[k*PW +: PW] = 16'd9;
      ph_v[k*PW +: PW]  = PW'(2 * k);
    end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    run(35);

    // burst of 3 on channel 1, retrigger while busy, then reset mid-burst
    en_v = 4'b0010; mode_v = 4'b0010;
    per_v[PW +: PW] = 16'd1; ph_v[PW +: PW] = 16'd0; bu_v[BW +: BW] = 8'd3;
    run(2);
    trig_v[1] = 1'b1; tick();
    trig_v[1] = 1'b0; tick();
    trig_v[1] = 1'b1; tick();
    trig_v[1] = 1'b0; run(8);
    bu_v[BW +: BW] = 8'd0;
    trig_v[1] = 1'b1; tick();
    trig_v[1] = 1'b0; run(3);
    bu_v[BW +: BW] = 8'd3;
    trig_v[1] = 1'b1; tick();
    trig_v[1] = 1'b0; run(2);
    rst = 1'b1; tick();
    rst = 1'b0; run(5);
    trig_v[1] = 1'b1; tick();
    trig_v[1] = 1'b0; run(8);

    // seeded PRNG with heavy jitter; intervals never shorter than period+1
    nojit_phase = 1'b0;
    seedv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      seedb = 8'($urandom);
      tick();
    end
    seedv = 1'b0;
    en_v = '1; mode_v = '0;
    for (int k = 0; k < N; k++) begin
      per_v[k*PW +: PW] = PW'($urandom_range(0, 5));
      last[k] = -1;
    end
    jit_v = {8'h10, 8'h40, 8'h80, 8'hFF};
    run(2);
    for (int i = 0; i < 300; i++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (strobe_o[k]) begin
          if (last[k] >= 0)
            chk("jitter_interval_min", 32'(cyc - last[k] >= int'(per_v[k*PW +: PW]) + 1), 32'd1);
          last[k] = cyc;
        end
      end
    end

    // randomized mix of every control
    for (int i = 0; i < 2000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      cg    = ($urandom_range(0, 9) != 0);
      sync  = ($urandom_range(0, 39) == 0);
      seedv = ($urandom_range(0, 29) == 0);
      seedb = 8'($urandom);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 49) == 0) en_v[k] = ~en_v[k];
        if ($urandom_range(0, 59) == 0) mode_v[k] = ~mode_v[k];
        trig_v[k] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 29) == 0) begin
          per_v[k*PW +: PW] = PW'($urandom_range(0, 7));
          ph_v[k*PW +: PW]  = PW'($urandom_range(0, 7));
          bu_v[k*BW +: BW]  = BW'($urandom_range(0, 4));
          jit_v[k*JW +: JW] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
